// File: rtl/bmu_iterative_unit.sv
// Multi-cycle bit-manipulation unit for the ops the single-cycle BMU defers:
// CLZ, CTZ, CPOP, CLMUL, CLMULH, CLMULR. Processes BITS_PER_CYCLE operand
// bits per RUN cycle and pulses done for one cycle when the result is ready.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   start      request, sampled only in IDLE
//   option     5-bit BMU operation encoding
//   BMU_in_X   operand rs1, captured when start is accepted
//   BMU_in_Y   operand rs2, captured when start is accepted (CLMUL* only)
//   busy       high while RUN or DONE
//   done       one-cycle result-valid pulse
//   BMU_out_S  result, held until the next accepted op completes
module bmu_iterative_unit #(
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [4:0]  option,
  input  logic [31:0] BMU_in_X,
  input  logic [31:0] BMU_in_Y,
  output logic        busy,
  output logic        done,
  output logic [31:0] BMU_out_S
);

  localparam int unsigned ITER = 32 / BITS_PER_CYCLE;
  localparam int unsigned CW   = 6;

  localparam logic [4:0] OP_CLMUL  = 5'b00001;
  localparam logic [4:0] OP_CLMULH = 5'b00010;
  localparam logic [4:0] OP_CLMULR = 5'b00011;
  localparam logic [4:0] OP_CLZ    = 5'b00100;
  localparam logic [4:0] OP_CPOP   = 5'b00101;
  localparam logic [4:0] OP_CTZ    = 5'b00110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [4:0]      r_op;
  logic [63:0]     r_xs;     // X pre-shifted to the current Y bit position
  logic [31:0]     r_y;      // remaining Y bits, LSB = next bit to process
  logic [31:0]     r_xw;     // scan word for counts, LSB = next bit to examine
  logic [63:0]     r_prod;
  logic [CW-1:0]   r_acc;
  logic            r_found;
  logic [CW-1:0]   r_cnt;

  logic [63:0]     w_prod;
  logic [CW-1:0]   w_acc;
  logic            w_found;
  logic [31:0]     w_x_rev;
  logic [31:0]     w_result;
  logic            w_legal;
  logic            w_last;
  logic            w_is_cpop;

  // Bit-reverse X so CLZ can reuse the LSB-first trailing-zero scan
  always_comb begin
    w_x_rev = '0;
    for (int k = 0; k < 32; k++) begin
      w_x_rev[k] = BMU_in_X[31-k];
    end
  end

  // Legal-option decode on the incoming request
  always_comb begin
    w_legal = 1'b0;
    case (option)
      OP_CLMUL, OP_CLMULH, OP_CLMULR,
      OP_CLZ, OP_CPOP, OP_CTZ: w_legal = 1'b1;
      default:                 w_legal = 1'b0;
    endcase
  end

  // One iteration: fold in BITS_PER_CYCLE product terms and scan bits
  always_comb begin
    w_prod    = r_prod;
    w_acc     = r_acc;
    w_found   = r_found;
    w_is_cpop = (r_op == OP_CPOP);
    for (int j = 0; j < int'(BITS_PER_CYCLE); j++) begin
      if (r_y[j]) begin
        w_prod = w_prod ^ (r_xs << j);
      end
      if (w_is_cpop) begin
        if (r_xw[j]) begin
          w_acc = w_acc + CW'(1);
        end
      end else if (!w_found) begin
        // first one bit freezes the zero count
        if (r_xw[j]) begin
          w_found = 1'b1;
        end else begin
          w_acc = w_acc + CW'(1);
        end
      end
    end
  end

  // Result select from the values produced by the final iteration
  always_comb begin
    w_result = '0;
    case (r_op)
      OP_CLMUL:  w_result = w_prod[31:0];
      OP_CLMULH: w_result = w_prod[63:32];
      OP_CLMULR: w_result = w_prod[62:31];
      default:   w_result = {26'd0, w_acc};
    endcase
  end

  assign w_last = (r_cnt == CW'(ITER - 1));

  // Control FSM with datapath registers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_op      <= '0;
      r_xs      <= '0;
      r_y       <= '0;
      r_xw      <= '0;
      r_prod    <= '0;
      r_acc     <= '0;
      r_found   <= 1'b0;
      r_cnt     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      BMU_out_S <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            if (w_legal) begin
              r_op    <= option;
              r_xs    <= {32'd0, BMU_in_X};
              r_y     <= BMU_in_Y;
              r_xw    <= (option == OP_CLZ) ? w_x_rev : BMU_in_X;
              r_prod  <= '0;
              r_acc   <= '0;
              r_found <= 1'b0;
              r_cnt   <= '0;
              r_state <= S_RUN;
            end else begin
              // unsupported op: skip RUN and return zero
              BMU_out_S <= '0;
              done      <= 1'b1;
              r_state   <= S_DONE;
            end
          end
        end
        S_RUN: begin
          r_prod  <= w_prod;
          r_acc   <= w_acc;
          r_found <= w_found;
          r_xs    <= r_xs << BITS_PER_CYCLE;
          r_y     <= r_y >> BITS_PER_CYCLE;
          r_xw    <= r_xw >> BITS_PER_CYCLE;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            BMU_out_S <= w_result;
            done      <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bmu_iterative_unit.sv
// Self-checking bench for bmu_iterative_unit: one instance at BITS_PER_CYCLE=1
// and one at 4 share the same inputs; a vector table covers the ops and
// hand-written sequences cover handshake, back-to-back and reset corners.
module tb_bmu_iterative_unit;

  localparam logic [4:0] OP_CLMUL  = 5'b00001;
  localparam logic [4:0] OP_CLMULH = 5'b00010;
  localparam logic [4:0] OP_CLMULR = 5'b00011;
  localparam logic [4:0] OP_CLZ    = 5'b00100;
  localparam logic [4:0] OP_CPOP   = 5'b00101;
  localparam logic [4:0] OP_CTZ    = 5'b00110;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  opt;
  logic [31:0] x;
  logic [31:0] y;
  logic        busy1, done1, busy4, done4;
  logic [31:0] s1, s4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bmu_iterative_unit #(.BITS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .option(opt),
    .BMU_in_X(x), .BMU_in_Y(y),
    .busy(busy1), .done(done1), .BMU_out_S(s1)
  );

  bmu_iterative_unit #(.BITS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start), .option(opt),
    .BMU_in_X(x), .BMU_in_Y(y),
    .busy(busy4), .done(done4), .BMU_out_S(s4)
  );

  typedef struct {
    string       name;
    bit          sel4;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          cyc;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic add(input string name, input bit sel4, input logic [4:0] op,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input int cyc);
    vec_t v;
    v.name = name; v.sel4 = sel4; v.op = op; v.a = a; v.b = b; v.exp = exp; v.cyc = cyc;
    vecs.push_back(v);
  endtask

  // Called just after a rising edge (cycle 0). Returns the done cycle, the
  // result and whether busy was high from cycle 1 through done and low after.
  task automatic run_op(input bit sel4, input logic [4:0] o, input logic [31:0] a,
                        input logic [31:0] b, output int dc, output logic [31:0] res,
                        output bit bok);
    logic bsy, dn;
    dc = -1; res = '0; bok = 1'b1;
    opt = o; x = a; y = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; x = ~a; y = ~b; opt = OP_CLZ;
    for (int c = 1; c <= 45 && dc < 0; c++) begin
      @(negedge clk);
      bsy = sel4 ? busy4 : busy1;
      dn  = sel4 ? done4 : done1;
      if (!bsy) bok = 1'b0;
      if (dn) begin
        dc  = c;
        res = sel4 ? s4 : s1;
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    bsy = sel4 ? busy4 : busy1;
    dn  = sel4 ? done4 : done1;
    if (bsy || dn) bok = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int dc, dc2, nd, act;
    logic [31:0] res, res2;
    bit bok;

    rst = 1'b1; start = 1'b0; opt = '0; x = '0; y = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset busy1", 32'(busy1), 32'd0);
    check("reset done1", 32'(done1), 32'd0);
    check("reset out1", s1, 32'd0);
    check("reset busy4", 32'(busy4), 32'd0);
    check("reset done4", 32'(done4), 32'd0);
    check("reset out4", s4, 32'd0);
    @(posedge clk); #1;

    add("b1 clmul  ends", 1'b0, OP_CLMUL,  32'h80000001, 32'h80000001, 32'h00000001, 33);
    add("b1 clmulh ends", 1'b0, OP_CLMULH, 32'h80000001, 32'h80000001, 32'h40000000, 33);
    add("b1 clmulr ends", 1'b0, OP_CLMULR, 32'h80000001, 32'h80000001, 32'h80000000, 33);
    add("b1 clmul  ones", 1'b0, OP_CLMUL,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h55555555, 33);
    add("b1 clmulh ones", 1'b0, OP_CLMULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h55555555, 33);
    add("b1 clmulr ones", 1'b0, OP_CLMULR, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hAAAAAAAA, 33);
    add("b1 clmul  3x3",  1'b0, OP_CLMUL,  32'h00000003, 32'h00000003, 32'h00000005, 33);
    add("b1 clz bit16",   1'b0, OP_CLZ,    32'h00010000, 32'h0,        32'd15,       33);
    add("b1 ctz bit16",   1'b0, OP_CTZ,    32'h00010000, 32'h0,        32'd16,       33);
    add("b1 cpop bit16",  1'b0, OP_CPOP,   32'h00010000, 32'h0,        32'd1,        33);
    add("b1 clz zero",    1'b0, OP_CLZ,    32'h00000000, 32'h0,        32'd32,       33);
    add("b1 ctz zero",    1'b0, OP_CTZ,    32'h00000000, 32'h0,        32'd32,       33);
    add("b1 cpop zero",   1'b0, OP_CPOP,   32'h00000000, 32'h0,        32'd0,        33);
    add("b1 cpop ones",   1'b0, OP_CPOP,   32'hFFFFFFFF, 32'h0,        32'd32,       33);
    add("b1 clz ones",    1'b0, OP_CLZ,    32'hFFFFFFFF, 32'h0,        32'd0,        33);
    add("b1 ctz ones",    1'b0, OP_CTZ,    32'hFFFFFFFF, 32'h0,        32'd0,        33);
    add("b1 illegal 00",  1'b0, 5'b00000,  32'h12345678, 32'h9ABCDEF0, 32'd0,        1);
    add("b1 illegal 07",  1'b0, 5'b00111,  32'h12345678, 32'h9ABCDEF0, 32'd0,        1);
    add("b4 clmul  3x3",  1'b1, OP_CLMUL,  32'h00000003, 32'h00000003, 32'h00000005, 9);
    add("b4 clmulh ends", 1'b1, OP_CLMULH, 32'h80000001, 32'h80000001, 32'h40000000, 9);
    add("b4 clmulr ones", 1'b1, OP_CLMULR, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hAAAAAAAA, 9);
    add("b4 clz bit16",   1'b1, OP_CLZ,    32'h00010000, 32'h0,        32'd15,       9);
    add("b4 ctz bit16",   1'b1, OP_CTZ,    32'h00010000, 32'h0,        32'd16,       9);
    add("b4 ctz zero",    1'b1, OP_CTZ,    32'h00000000, 32'h0,        32'd32,       9);
    add("b4 cpop f0",     1'b1, OP_CPOP,   32'hF0F0F0F0, 32'h0,        32'd16,       9);
    add("b4 illegal 1f",  1'b1, 5'b11111,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        1);

    foreach (vecs[i]) begin
      run_op(vecs[i].sel4, vecs[i].op, vecs[i].a, vecs[i].b, dc, res, bok);
      check({vecs[i].name, " result"}, res, vecs[i].exp);
      check({vecs[i].name, " done cycle"}, 32'(dc), 32'(vecs[i].cyc));
      check({vecs[i].name, " busy window"}, 32'(bok), 32'd1);
    end

    // let the width-1 instance drain work started by the width-4 vectors
    repeat (40) @(posedge clk);
    #1;

    // second start during RUN is ignored
    opt = OP_CPOP; x = 32'hF0F0F0F0; y = '0; start = 1'b1;
    @(posedge clk); #1;
    dc = -1; res = '0; nd = 0;
    for (int c = 1; c <= 40; c++) begin
      start = (c == 10);
      x = (c == 10) ? 32'h00000000 : 32'hF0F0F0F0;
      @(negedge clk);
      if (done1) begin
        nd++;
        if (dc < 0) begin dc = c; res = s1; end
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("ignored start result", res, 32'd16);
    check("ignored start done cycle", 32'(dc), 32'd33);
    check("ignored start done count", 32'(nd), 32'd1);
    repeat (20) @(posedge clk);
    #1;

    // start held high through DONE is accepted in the following IDLE cycle
    opt = OP_CPOP; x = 32'hFFFFFFFF; start = 1'b1;
    @(posedge clk); #1;
    x = 32'h000000FF;
    dc = -1; dc2 = -1; res = '0; res2 = '0; nd = 0;
    for (int c = 1; c <= 80; c++) begin
      if (c == 35) start = 1'b0;
      @(negedge clk);
      if (c == 34) check("b2b idle gap busy", 32'(busy1), 32'd0);
      if (c == 35) check("b2b second busy", 32'(busy1), 32'd1);
      if (done1) begin
        nd++;
        if (dc < 0) begin dc = c; res = s1; end
        else if (dc2 < 0) begin dc2 = c; res2 = s1; end
      end
      @(posedge clk); #1;
    end
    check("b2b first result", res, 32'd32);
    check("b2b first done cycle", 32'(dc), 32'd33);
    check("b2b second result", res2, 32'd8);
    check("b2b second done cycle", 32'(dc2), 32'd67);
    check("b2b done count", 32'(nd), 32'd2);
    repeat (20) @(posedge clk);
    #1;

    // reset mid-RUN, with start held during reset, aborts and loses the start
    opt = OP_CLMUL; x = 32'h00000003; y = 32'h00000003; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    check("pre-reset busy1", 32'(busy1), 32'd1);
    rst = 1'b1; start = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("midrun reset busy1", 32'(busy1), 32'd0);
    check("midrun reset done1", 32'(done1), 32'd0);
    check("midrun reset out1", s1, 32'd0);
    check("midrun reset out4", s4, 32'd0);
    act = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done1 || done4 || busy1 || busy4) act++;
    end
    check("post-reset activity", 32'(act), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
